// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared types and constants for the RV32I pipeline hazard
// controller.
//   FWD_*          EX operand select encodings
//   stage_ctl_t    ID/EX shadow fields {valid, rs1, rs2, rd, reg_write, mem_read}
//   exmem_ctl_t    EX/MEM shadow fields (source registers no longer needed)
//   memwb_ctl_t    MEM/WB shadow fields (load flag no longer needed: a load's
//                  data is ready for forwarding once it reaches write-back)
//   *_BUBBLE       all-zero stage contents
package rv32_pipe_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } stage_ctl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
  } exmem_ctl_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
  } memwb_ctl_t;

  localparam stage_ctl_t STAGE_BUBBLE = '0;
  localparam exmem_ctl_t EXMEM_BUBBLE = '0;
  localparam memwb_ctl_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/pipeline_ctrl_fwd_pick.sv
// fwd_pick: combinational forwarding select for one EX-stage source operand.
//   src    source register read by the instruction currently in EX
//   exmem  EX/MEM shadow fields
//   memwb  MEM/WB shadow fields
//   sel    FWD_EXMEM / FWD_MEMWB / FWD_REG
// A load sitting in EX/MEM has no data yet, so it never forwards from there;
// the load-use stall guarantees the consumer meets it again in MEM/WB.
module fwd_pick
  import rv32_pipe_pkg::*;
(
  input  logic [4:0] src,
  input  exmem_ctl_t exmem,
  input  memwb_ctl_t memwb,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (exmem.valid && exmem.reg_write && !exmem.mem_read &&
        (exmem.rd != 5'd0) && (exmem.rd == src)) begin
      sel = FWD_EXMEM;
    end else if (memwb.valid && memwb.reg_write &&
                 (memwb.rd != 5'd0) && (memwb.rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the 5-stage RV32I pipe.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   id_*                       decoded fields of the instruction in ID
//   ex_branch_taken            branch/jump in EX resolved taken
//   stall                      hold PC and IF/ID (load-use hazard)
//   flush_ifid, flush_idex     squash IF/ID and the ID/EX load (taken branch)
//   forwardA, forwardB         EX operand selects
//   wb_en, wb_rd               register-bank write port
//   stall_cnt, flush_cnt       saturating event counters
module pipeline_ctrl
  import rv32_pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  stage_ctl_t idex_p0;
  exmem_ctl_t exmem_p1;
  memwb_ctl_t memwb_p2;
  stage_ctl_t idex_nxt;

  logic taken;
  logic src_match;
  logic load_use;

  always_comb begin
    // A branch resolving with a bubble in EX is not a real branch.
    taken     = ex_branch_taken & idex_p0.valid;
    src_match = (id_uses_rs1 && (id_rs1 == idex_p0.rd)) ||
                (id_uses_rs2 && (id_rs2 == idex_p0.rd));
    load_use  = id_valid && idex_p0.valid && idex_p0.mem_read &&
                (idex_p0.rd != 5'd0) && src_match;
    // The branch squashes the stalled instruction, so it wins.
    stall      = load_use & ~taken;
    flush_ifid = taken;
    flush_idex = taken;

    idex_nxt = STAGE_BUBBLE;
    if (id_valid && !taken && !stall) begin
      idex_nxt.valid     = 1'b1;
      idex_nxt.rs1       = id_rs1;
      idex_nxt.rs2       = id_rs2;
      idex_nxt.rd        = id_rd;
      // x0 destinations are treated as no-writes so nothing downstream
      // ever forwards, stalls on, or writes x0.
      idex_nxt.reg_write = id_reg_write & (id_rd != 5'd0);
      idex_nxt.mem_read  = id_mem_read & (id_rd != 5'd0);
    end

    wb_en = memwb_p2.valid & memwb_p2.reg_write & (memwb_p2.rd != 5'd0);
    wb_rd = memwb_p2.valid ? memwb_p2.rd : 5'd0;
  end

  // ---- stage boundary: ID -> EX -> MEM -> WB ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_p0   <= STAGE_BUBBLE;
      exmem_p1  <= EXMEM_BUBBLE;
      memwb_p2  <= MEMWB_BUBBLE;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      idex_p0  <= idex_nxt;
      exmem_p1 <= '{valid:     idex_p0.valid,
                    rd:        idex_p0.rd,
                    reg_write: idex_p0.reg_write,
                    mem_read:  idex_p0.mem_read};
      memwb_p2 <= '{valid:     exmem_p1.valid,
                    rd:        exmem_p1.rd,
                    reg_write: exmem_p1.reg_write};
      if (stall) stall_cnt <= sat_inc(stall_cnt);
      if (taken) flush_cnt <= sat_inc(flush_cnt);
    end
  end

  fwd_pick u_fwd_a (
    .src   (idex_p0.rs1),
    .exmem (exmem_p1),
    .memwb (memwb_p2),
    .sel   (forwardA)
  );

  fwd_pick u_fwd_b (
    .src   (idex_p0.rs2),
    .exmem (exmem_p1),
    .memwb (memwb_p2),
    .sel   (forwardB)
  );

endmodule
